npc_ctrl: RTL
=============

Name: npc_ctrl

Overview:
- Next-PC controller directly upstream of the instruction fetch unit.
- Each cycle it takes the current PC and fetched instruction, decodes control-flow ops (beq, bne, j, jal, jr, jalr), and drives NPC back into the fetch PC register.
- Implements the MIPS branch delay slot with a small state machine, honours pipeline stall, and keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_3000, PC value the fetch unit resets to; NPC value driven during reset.
- DELAY_SLOT, 1, 1 = one architectural delay slot after taken control flow; 0 = redirect on the very next fetch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- pc  input  32  current fetch PC from fetch unit.
- instr  input  32  instruction at pc.
- rs_val  input  32  GPR[rs] value for jr/jalr and branch compare.
- rt_val  input  32  GPR[rt] value for branch compare.
- stall  input  1  1 = hold fetch this cycle.
- npc  output  32  next PC to fetch unit.
- link_addr  output  32  return address for jal/jalr: pc+8 when DELAY_SLOT=1, pc+4 when 0.
- redirect  output  1  1 in the cycle npc is a non-sequential target.
- slot_err  output  1  sticky; set when a control-flow op is fetched in a delay slot.
- fetch_cnt  output  32  count of non-stalled, non-reset cycles.

Behaviour:
- Decode, combinational on instr:
  - beq op=6'b000100; bne op=6'b000101; j op=6'b000010; jal op=6'b000011.
  - jr op=0, funct=6'b001000; jalr op=0, funct=6'b001001.
  - All other encodings are sequential.
- Targets, all 32-bit, wrap modulo 2^32:
  - Branch: pc+4+(sext(instr[15:0])<<2).
  - j/jal: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - jr/jalr: rs_val.
- Taken:
  - beq when rs_val==rt_val; bne when rs_val!=rt_val.
  - j/jal/jr/jalr always taken.
- State machine, DELAY_SLOT=1: states SEQ, SLOT. Registers: state, tgt_q (32b).
  - SEQ, stall=1: npc=pc, no state change, redirect=0.
  - SEQ, taken control op: npc=pc+4 (delay slot), tgt_q<=target, state<=SLOT, redirect=0.
  - SEQ, otherwise: npc=pc+4.
  - SLOT, stall=1: npc=pc, state and tgt_q held.
  - SLOT, no stall: npc=tgt_q, redirect=1, state<=SEQ.
  - SLOT, instr is a control op: decoded as sequential (no new target captured), slot_err<=1; npc still tgt_q.
- DELAY_SLOT=0: state machine collapses to SEQ.
  - Taken op: npc=target, redirect=1, same cycle.
  - tgt_q unused; slot_err stays 0.
- Stall has priority over everything except reset: npc=pc, redirect=0, fetch_cnt held.
- fetch_cnt increments by 1 on each rising edge with reset=1 and stall=0; wraps 32'hFFFF_FFFF -> 0.
- Reset (reset=0 at rising edge): state<=SEQ, tgt_q<=0, slot_err<=0, fetch_cnt<=0.
  - While reset=0: npc=RESET_PC, redirect=0.
  - Reset in SLOT discards the pending target.
- link_addr is combinational from pc, independent of stall and state.
- No combinational path from npc back to pc; the fetch unit registers npc.

Test Plan:
- Reset then sequential: reset=0 for 2 cycles, then pc=0x3000, instr=0 -> npc=0x3004; fetch_cnt=1 after first free edge; redirect=0.
- beq taken with delay slot: pc=0x3010, instr=0x1000_0003, rs_val=rt_val=5 -> npc=0x3014. Next cycle (pc=0x3014, instr=0) -> npc=0x3020, redirect=1. Same stimulus with rt_val=6 -> 0x3014 then 0x3018.
- jal and link: pc=0x3000, instr=0x0C00_0C10 -> link_addr=0x3008; npc=0x3004, then 0x3040 in the slot cycle.
- jr with stall in slot: pc=0x3020, instr=0x03E0_0008, rs_val=0x3100. Slot cycle with stall=1 for 3 cycles -> npc=pc held, fetch_cnt frozen. stall=0 -> npc=0x3100.
- Slot error and mid-op reset: j at 0x3000, then instr=j in the slot -> slot_err=1, npc=first target. Then reset=0 while in SLOT -> npc=0x3000, slot_err=0, fetch_cnt=0, next free cycle sequential.
- Wrap: pc=0xFFFF_FFFC, instr=0 -> npc=0x0000_0000. Force fetch_cnt to 0xFFFF_FFFF, one free edge -> 0.

Source files
------------

// File: rtl/npc_ctrl.sv
// Next-PC controller: decodes MIPS control-flow ops and steers the fetch PC.
// Taken control flow can be deferred by one architectural delay slot.
module npc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        stall,
    output logic [31:0] npc,
    output logic [31:0] link_addr,
    output logic        redirect,
    output logic        slot_err,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [0:0] {StSeq, StSlot} state_e;

    state_e      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
    logic        is_ctrl, taken;
    logic [31:0] pc_plus4, br_tgt, j_tgt, target;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    assign is_beq  = (op == 6'b000100);
    assign is_bne  = (op == 6'b000101);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign is_jr   = (op == 6'b000000) && (funct == 6'b001000);
    assign is_jalr = (op == 6'b000000) && (funct == 6'b001001);
    assign is_ctrl = is_beq | is_bne | is_j | is_jal | is_jr | is_jalr;

    assign taken = (is_beq & (rs_val == rt_val)) | (is_bne & (rs_val != rt_val)) |
                   is_j | is_jal | is_jr | is_jalr;

    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign j_tgt    = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        target = rs_val;
        if (is_beq || is_bne) begin
            target = br_tgt;
        end else if (is_j || is_jal) begin
            target = j_tgt;
        end
    end

    // Return address skips the delay-slot instruction when one exists.
    assign link_addr = (DELAY_SLOT != 0) ? pc + 32'd8 : pc_plus4;

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        npc      = pc_plus4;
        redirect = 1'b0;
        if (!reset) begin
            npc = RESET_PC;
        end else if (stall) begin
            npc = pc;
        end else begin
            cnt_d = cnt_q + 32'd1;
            if (DELAY_SLOT != 0) begin
                unique case (state_q)
                    StSeq: begin
                        if (taken) begin
                            tgt_d   = target;
                            state_d = StSlot;
                        end
                    end
                    StSlot: begin
                        // Control ops in the slot are ignored apart from flagging the error.
                        npc      = tgt_q;
                        redirect = 1'b1;
                        state_d  = StSeq;
                        if (is_ctrl) begin
                            err_d = 1'b1;
                        end
                    end
                endcase
            end else if (taken) begin
                npc      = target;
                redirect = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StSeq;
            tgt_q   <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign slot_err  = err_q;
    assign fetch_cnt = cnt_q;

endmodule
